down_timer_ctrl: RTL and testbench



---
 rtl/down_timer_pkg.sv | 19 +
 rtl/down_timer_ctrl_tick_gen.sv | 34 +++
 rtl/down_timer_ctrl.sv | 98 +++++++++
 tb/tb_down_timer_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/down_timer_pkg.sv
// Shared types and constants for the programmable down-count timer.
// The width helper keeps the prescaler at least one bit wide when PRESCALE is 1.
package down_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_PRESCALE = 4;

  function automatic int ps_width(input int prescale);
    int w;
    w = $clog2(prescale);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/down_timer_ctrl_tick_gen.sv
// PRESCALE-cycle prescaler: counts while enabled, clears on request, and flags
// the cycle in which it wraps so the caller can decrement on that same edge.
module tick_gen
  import down_timer_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int PS_W     = ps_width(DEF_PRESCALE)
) (
  input  logic CLK,
  input  logic Reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_cnt;

  // The tick is decoded from the registered phase so the decrement lands on
  // the very edge where the prescaler wraps back to zero.
  assign tick = en && !clr && (ps_cnt == PS_LAST);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      ps_cnt <= '0;
    end else if (clr) begin
      ps_cnt <= '0;
    end else if (en) begin
      ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + PS_W'(1);
    end
  end

endmodule

// File: rtl/down_timer_ctrl.sv
// Loadable down-count timer with one-shot and auto-reload modes. Decrements
// once per prescaled tick and pulses Done for one cycle at terminal count.
module down_timer_ctrl
  import down_timer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Mode,
  input  logic [WIDTH-1:0] Load_val,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             Done
);

  localparam int PS_W = ps_width(PRESCALE);

  state_t           state;
  logic [WIDTH-1:0] reload_r;
  logic             mode_r;
  logic             tick;
  logic             load_zero;
  logic             accept;
  logic             abort;
  logic             ps_clr;
  logic             ps_en;

  assign load_zero = (Load_val == '0);
  assign accept    = (state == IDLE) && Start && !Stop && !load_zero;
  // Stop outranks everything in RUN, including a terminal decrement.
  assign abort     = (state == RUN) && Stop;
  assign ps_clr    = accept || abort;
  assign ps_en     = (state == RUN);

  tick_gen #(
    .PRESCALE(PRESCALE),
    .PS_W    (PS_W)
  ) u_tick_gen (
    .CLK  (CLK),
    .Reset(Reset),
    .en   (ps_en),
    .clr  (ps_clr),
    .tick (tick)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      Count    <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      reload_r <= '0;
      mode_r   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start && load_zero) begin
            Done  <= 1'b1;
            Count <= '0;
          end else if (accept) begin
            Count    <= Load_val;
            reload_r <= Load_val;
            mode_r   <= Mode;
            Busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            Busy  <= 1'b0;
            state <= IDLE;
          end else if (tick) begin
            if (Count == WIDTH'(1)) begin
              Done <= 1'b1;
              // Auto-reload skips zero entirely and keeps running.
              if (mode_r) begin
                Count <= reload_r;
              end else begin
                Count <= '0;
                Busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              Count <= Count - WIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_down_timer_ctrl.sv
// Bench for down_timer_ctrl: two instances (PRESCALE 4 and 1) share stimulus
// and are compared every cycle against a cycles-remaining reference model.
module tb_down_timer_ctrl;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         Reset;
  logic         Start, Stop, Mode;
  logic [W-1:0] Load_val;
  logic [W-1:0] cnt0, cnt1;
  logic         busy0, busy1, done0, done1;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state, index 0 = PRESCALE 4, index 1 = PRESCALE 1.
  int ps_of [2] = '{4, 1};
  int m_cnt [2];
  int m_busy[2];
  int m_done[2];
  int m_rel [2];
  int m_mode[2];
  int m_left[2];

  always #5 CLK = ~CLK;

  down_timer_ctrl #(.WIDTH(W), .PRESCALE(4)) dut0 (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Stop(Stop), .Mode(Mode),
    .Load_val(Load_val), .Count(cnt0), .Busy(busy0), .Done(done0)
  );

  down_timer_ctrl #(.WIDTH(W), .PRESCALE(1)) dut1 (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Stop(Stop), .Mode(Mode),
    .Load_val(Load_val), .Count(cnt1), .Busy(busy1), .Done(done1)
  );

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_busy[k] = 0; m_done[k] = 0;
      m_rel[k] = 0; m_mode[k] = 0; m_left[k] = 0;
    end
  endtask

  // One clock edge of the timer, described as "edges left until next decrement".
  task automatic model_step(input int st, input int sp, input int md, input int lv);
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 0;
      if (m_busy[k] == 0) begin
        if (st != 0 && lv == 0) begin
          m_done[k] = 1;
          m_cnt[k]  = 0;
        end else if (st != 0 && sp == 0) begin
          m_cnt[k] = lv; m_rel[k] = lv; m_mode[k] = md;
          m_busy[k] = 1; m_left[k] = ps_of[k];
        end
      end else if (sp != 0) begin
        m_busy[k] = 0;
      end else begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_left[k] = ps_of[k];
          if (m_cnt[k] == 1) begin
            m_done[k] = 1;
            if (m_mode[k] != 0) m_cnt[k] = m_rel[k];
            else begin m_cnt[k] = 0; m_busy[k] = 0; end
          end else begin
            m_cnt[k] = m_cnt[k] - 1;
          end
        end
      end
    end
  endtask

  task automatic cycle(input int st, input int sp, input int md, input int lv);
    @(negedge CLK);
    Start = st[0]; Stop = sp[0]; Mode = md[0]; Load_val = W'(lv);
    @(posedge CLK);
    model_step(st, sp, md, lv);
    #1;
    chk("cnt0", cnt0, m_cnt[0]);  chk("busy0", busy0, m_busy[0]); chk("done0", done0, m_done[0]);
    chk("cnt1", cnt1, m_cnt[1]);  chk("busy1", busy1, m_busy[1]); chk("done1", done1, m_done[1]);
  endtask

  initial begin
    int edge_n, done_n, first_done, guard;
    Start = 0; Stop = 0; Mode = 0; Load_val = '0;
    Reset = 1'b0;
    model_reset();
    #12;
    chk("rst_cnt", cnt0, 0); chk("rst_busy", busy0, 0); chk("rst_done", done0, 0);
    chk("rst_cnt1", cnt1, 0);
    @(negedge CLK); Reset = 1'b1;

    // 1: one-shot, Load_val=3 -> Done on edge 12 after the load edge.
    cycle(1, 0, 0, 3);
    chk("t1_load_cnt", cnt0, 3); chk("t1_load_busy", busy0, 1);
    edge_n = 0; first_done = -1;
    while (first_done < 0 && edge_n < 40) begin
      cycle(0, 0, 0, 0); edge_n++;
      if (edge_n == 4) chk("t1_e4", cnt0, 2);
      if (edge_n == 8) chk("t1_e8", cnt0, 1);
      if (done0) first_done = edge_n;
    end
    chk("t1_done_edge", first_done, 12);
    chk("t1_end_cnt", cnt0, 0); chk("t1_end_busy", busy0, 0);
    cycle(0, 0, 0, 0);
    chk("t1_done_once", done0, 0);

    // 2: auto-reload, Load_val=2 -> Done after edges 8, 16, 24.
    cycle(0, 1, 0, 0);
    cycle(1, 0, 1, 2);
    done_n = 0; first_done = -1;
    for (int e = 1; e <= 26; e++) begin
      cycle(0, 0, 0, 0);
      if (done0) begin
        done_n++;
        if (first_done < 0) first_done = e;
      end
    end
    chk("t2_done_cnt", done_n, 3); chk("t2_first", first_done, 8);
    chk("t2_busy", busy0, 1);

    // 3: Stop and Start together in RUN at Count=2.
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 3);
    guard = 0;
    while (cnt0 != 2 && guard < 20) begin cycle(0, 0, 0, 0); guard++; end
    chk("t3_reach2", cnt0, 2);
    cycle(1, 1, 0, 7);
    chk("t3_cnt", cnt0, 2); chk("t3_busy", busy0, 0); chk("t3_done", done0, 0);
    cycle(1, 0, 0, 5);
    chk("t3_reload", cnt0, 5);

    // 4: zero load gives a lone Done; Start during RUN is ignored.
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    chk("t4_done", done0, 1); chk("t4_busy", busy0, 0); chk("t4_cnt", cnt0, 0);
    cycle(1, 0, 0, 3);
    cycle(1, 0, 1, 9);
    chk("t4_ignore", cnt0, 3);
    for (int e = 0; e < 3; e++) cycle(0, 0, 0, 0);
    chk("t4_cont", cnt0, 2);

    // 5: brief asynchronous reset mid-RUN at Count=7.
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 7);
    chk("t5_cnt7", cnt0, 7);
    #2 Reset = 1'b0;
    #1;
    chk("t5_cnt", cnt0, 0); chk("t5_busy", busy0, 0); chk("t5_done", done0, 0);
    Reset = 1'b1;
    model_reset();

    // 6: PRESCALE=1 instance, Load_val=15 one-shot -> Done 15 edges later.
    cycle(1, 0, 0, 15);
    edge_n = 0; first_done = -1;
    while (first_done < 0 && edge_n < 40) begin
      cycle(0, 0, 0, 0); edge_n++;
      if (done1) first_done = edge_n;
    end
    chk("t6_done_edge", first_done, 15);

    // Random traffic against the model.
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      int st, sp, lv;
      st = ($urandom_range(0, 3) == 0) ? 1 : 0;
      sp = ($urandom_range(0, 15) == 0) ? 1 : 0;
      lv = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
      cycle(st, sp, $urandom_range(0, 1), lv);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
